aggregation_block: RTL and testbench



---
 rtl/aggregation_block_if.sv | 32 +++
 rtl/aggregation_block.sv | 113 +++++++++++
 tb/tb_aggregation_block.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/aggregation_block_if.sv
// Handshake and memory-bus bundle for aggregation_block: control, adjacency/product
// memory ports and the aggregated-row output stream.
interface aggregation_block_if #(
    parameter int NUM_NODES      = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int AGG_WIDTH      = DOT_PROD_WIDTH + $clog2(NUM_NODES)
);
    localparam int IW = $clog2(NUM_NODES);

    logic                                start;
    logic [IW-1:0]                       adj_row_addr;
    logic [NUM_NODES-1:0]                adj_row_in;
    logic [IW-1:0]                       fm_wm_read_row;
    logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] fm_wm_row_in;
    logic                                out_valid;
    logic                                out_ready;
    logic [IW-1:0]                       out_row_addr;
    logic [WEIGHT_COLS*AGG_WIDTH-1:0]    agg_row_out;
    logic                                busy;
    logic                                done;

    modport master (
        input  start, adj_row_in, fm_wm_row_in, out_ready,
        output adj_row_addr, fm_wm_read_row, out_valid, out_row_addr, agg_row_out, busy, done
    );

    modport slave (
        output start, adj_row_in, fm_wm_row_in, out_ready,
        input  adj_row_addr, fm_wm_read_row, out_valid, out_row_addr, agg_row_out, busy, done
    );
endinterface

// File: rtl/aggregation_block.sv
// Graph aggregation: for each node i, sums the product rows FMWM[j] of all neighbours j
// (adjacency bit adj[i][j]) and streams the aggregated row out with a valid/ready handshake.
module aggregation_block #(
    parameter int NUM_NODES      = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int AGG_WIDTH      = DOT_PROD_WIDTH + $clog2(NUM_NODES)
) (
    input  logic                clk,
    input  logic                reset,
    aggregation_block_if.master bus
);
    localparam int            IW   = $clog2(NUM_NODES);
    localparam logic [IW-1:0] LAST = IW'(NUM_NODES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        EMIT,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [IW-1:0]                           i;
    logic [IW-1:0]                           j;
    logic [IW-1:0]                           j_d;
    logic                                    nb_d;
    logic                                    issue_v;
    logic [WEIGHT_COLS-1:0][AGG_WIDTH-1:0]   acc;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        bus.adj_row_addr   = '0;
        bus.fm_wm_read_row = '0;
        bus.out_valid      = 1'b0;
        bus.out_row_addr   = '0;
        bus.agg_row_out    = '0;
        bus.busy           = (state_q != IDLE);
        bus.done           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = ISSUE;
            end
            ISSUE: begin
                bus.fm_wm_read_row = j;
                bus.adj_row_addr   = i;
                if (j == LAST) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = EMIT;
            end
            EMIT: begin
                bus.out_valid    = 1'b1;
                bus.out_row_addr = i;
                bus.agg_row_out  = acc;
                if (bus.out_ready) state_d = (i == LAST) ? FINISH : ISSUE;
            end
            FINISH: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The product memory answers one cycle late, so the neighbour bit travels
    // alongside in nb_d/issue_v and the add happens on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            i       <= '0;
            j       <= '0;
            j_d     <= '0;
            nb_d    <= 1'b0;
            issue_v <= 1'b0;
            acc     <= '0;
        end else begin
            issue_v <= (state_q == ISSUE);
            if (state_q == ISSUE) begin
                j_d  <= j;
                nb_d <= bus.adj_row_in[j];
                j    <= (j == LAST) ? '0 : j + 1'b1;
            end
            if (issue_v && nb_d) begin
                for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
                    acc[c] <= acc[c] + AGG_WIDTH'(bus.fm_wm_row_in[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]);
                end
            end
            if (state_q == IDLE && bus.start) begin
                i   <= '0;
                j   <= '0;
                acc <= '0;
            end
            if (state_q == EMIT && bus.out_ready && i != LAST) begin
                i   <= i + 1'b1;
                acc <= '0;
            end
        end
    end

    // The row absorbed in DRAIN must be the last neighbour index of the pass.
    always_ff @(posedge clk) begin
        if (!reset && state_q == DRAIN) begin
            assert (issue_v && j_d == LAST);
        end
    end
endmodule

// File: tb/tb_aggregation_block.sv
// Randomised self-checking bench for aggregation_block against a matrix-product reference model.
module tb_aggregation_block;
    localparam int NN = 6;
    localparam int WC = 3;
    localparam int DW = 16;
    localparam int AW = DW + $clog2(NN);
    localparam int IW = $clog2(NN);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aggregation_block_if #(
        .NUM_NODES(NN), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW), .AGG_WIDTH(AW)
    ) bus ();

    aggregation_block #(
        .NUM_NODES(NN), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW), .AGG_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    bit          adj_m [NN][NN];
    int unsigned fm_m  [NN][WC];
    int unsigned exp_m [NN][WC];

    int n_cmp = 0;
    int n_err = 0;

    // Combinational adjacency memory and registered product memory.
    always_comb begin
        bus.adj_row_in = '0;
        if (int'(bus.adj_row_addr) < NN)
            for (int k = 0; k < NN; k++) bus.adj_row_in[k] = adj_m[bus.adj_row_addr][k];
    end

    always @(posedge clk) begin
        for (int c = 0; c < WC; c++)
            if (int'(bus.fm_wm_read_row) < NN)
                bus.fm_wm_row_in[c*DW +: DW] <= fm_m[bus.fm_wm_read_row][c][DW-1:0];
            else
                bus.fm_wm_row_in[c*DW +: DW] <= '0;
    end

    task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void compute_model();
        for (int r = 0; r < NN; r++)
            for (int c = 0; c < WC; c++) begin
                exp_m[r][c] = 0;
                for (int k = 0; k < NN; k++)
                    if (adj_m[r][k]) exp_m[r][c] += fm_m[k][c];
            end
    endfunction

    function automatic void fill_random(input int zero_row);
        for (int r = 0; r < NN; r++)
            for (int k = 0; k < NN; k++)
                adj_m[r][k] = (r == zero_row) ? 1'b0 : 1'($urandom_range(0, 1));
        for (int k = 0; k < NN; k++)
            for (int c = 0; c < WC; c++) fm_m[k][c] = $urandom_range(0, 65535);
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_valid"}, bus.out_valid, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_done"}, bus.done, 0);
        check_eq({tag, "_agg"}, bus.agg_row_out, 0);
        check_eq({tag, "_oaddr"}, bus.out_row_addr, 0);
        check_eq({tag, "_rdrow"}, bus.fm_wm_read_row, 0);
        check_eq({tag, "_adjaddr"}, bus.adj_row_addr, 0);
    endtask

    // One full pass. stall_row<0: no backpressure; poke_cyc: cycle of a stray start;
    // abort_cyc: cycle in which reset is raised (pass is then abandoned).
    task automatic run_pass(input int stall_row, input int stall_len, input int poke_cyc, input int abort_cyc);
        int  cyc        = 1;
        int  rows       = 0;
        int  stall_left = (stall_row >= 0) ? stall_len : 0;
        int  exp_done   = 8*NN + 1 + stall_left;
        bit  seen_done  = 1'b0;
        logic [WC*AW-1:0] held_row, v;
        logic [IW-1:0]    held_addr;

        compute_model();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check_eq("busy_after_start", bus.busy, 1);
        while (!seen_done && cyc < 400) begin
            bus.start = (cyc == poke_cyc);
            if (cyc == abort_cyc) begin
                check_eq("abort_in_drain_busy", bus.busy, 1);
                rst = 1'b1;
                @(negedge clk);
                check_quiet("abort");
                rst = 1'b0;
                for (int k = 0; k < 60; k++) begin
                    @(negedge clk);
                    if (bus.out_valid || bus.done || bus.busy) begin
                        check_eq("abort_stays_idle", {bus.out_valid, bus.done, bus.busy}, 0);
                        break;
                    end
                end
                return;
            end
            if (bus.out_valid && int'(bus.out_row_addr) == stall_row && stall_left > 0) begin
                if (stall_left == stall_len) begin
                    held_row  = bus.agg_row_out;
                    held_addr = bus.out_row_addr;
                end else begin
                    check_eq("stall_row_stable", bus.agg_row_out, held_row);
                    check_eq("stall_addr_stable", bus.out_row_addr, held_addr);
                    check_eq("stall_valid", bus.out_valid, 1);
                end
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                check_eq("row_addr", bus.out_row_addr, rows);
                v = bus.agg_row_out;
                for (int c = 0; c < WC; c++)
                    if (rows < NN) check_eq($sformatf("row%0d_col%0d", rows, c), v[c*AW +: AW], exp_m[rows][c]);
                rows++;
            end
            if (bus.done) begin
                seen_done = 1'b1;
                check_eq("done_cycle", cyc, exp_done);
                check_eq("rows_transferred", rows, NN);
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("done_seen", seen_done, 1);
        check_quiet("after_done");
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        fill_random(-1);
        repeat (3) @(negedge clk);
        check_quiet("reset");

        // Reset wins over a simultaneous start.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check_quiet("reset_priority");

        // Identity adjacency, FMWM[j][c] = 10j + c.
        for (int r = 0; r < NN; r++)
            for (int k = 0; k < NN; k++) adj_m[r][k] = (r == k);
        for (int k = 0; k < NN; k++)
            for (int c = 0; c < WC; c++) fm_m[k][c] = 10*k + c;
        run_pass(-1, 0, -1, -1);

        // All neighbours, maximum elements: no wrap at the top bit.
        for (int r = 0; r < NN; r++)
            for (int k = 0; k < NN; k++) adj_m[r][k] = 1'b1;
        for (int k = 0; k < NN; k++)
            for (int c = 0; c < WC; c++) fm_m[k][c] = 32'hFFFF;
        run_pass(-1, 0, -1, -1);

        fill_random(3);
        run_pass(-1, 0, -1, -1);

        fill_random(-1);
        run_pass(2, 5, -1, -1);

        fill_random(-1);
        run_pass(-1, 0, 10, -1);

        fill_random(-1);
        run_pass(-1, 0, -1, 39);
        run_pass(-1, 0, -1, -1);

        for (int t = 0; t < 4; t++) begin
            fill_random(-1);
            run_pass(int'($urandom_range(0, NN-1)), int'($urandom_range(1, 7)), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
